// File: rtl/comp_minmax_tracker_pkg.sv
// Shared definitions for the window min/max tracker.
//   - State encoding for the IDLE / ACCUM / REPORT controller.
//   - Sample width and default window geometry.
package comp_minmax_tracker_pkg;

    localparam int DATA_W          = 16;
    localparam int DEFAULT_WIN_LEN = 8;
    localparam int DEFAULT_IDX_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_REPORT = 2'd2
    } state_t;

endpackage : comp_minmax_tracker_pkg

// File: rtl/comp_minmax_tracker_comp_16.sv
// comp_16: 16-bit unsigned magnitude comparator, purely combinational.
// Ports:
//   a, b       : operands (unsigned)
//   in_A_G_B   : cascade input, decides the "greater" result when a == b
//   out_A_G_B  : a > b (or a == b with in_A_G_B set)
//   out_A_L_B  : a < b
module comp_16
    import comp_minmax_tracker_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              in_A_G_B,
    output logic              out_A_G_B,
    output logic              out_A_L_B
);

    logic gt_s;
    logic eq_s;

    // Magnitude compare with cascade resolution on equality.
    always_comb begin
        gt_s      = (a > b);
        eq_s      = (a == b);
        out_A_G_B = gt_s | (eq_s & in_A_G_B);
        out_A_L_B = (a < b);
    end

endmodule : comp_16

// File: rtl/comp_minmax_tracker.sv
// comp_minmax_tracker: collects a window of WIN_LEN unsigned samples over a
// valid/ready stream, tracks the maximum and minimum with the index of the
// first occurrence of each, then offers the result on a valid/ready port.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : opens a window (only honoured in IDLE)
//   in_valid/in_ready : sample handshake, in_ready high only in ACCUM
//   in_data           : unsigned sample
//   out_valid/out_ready : result handshake, out_valid high only in REPORT
//   out_max, out_min  : window extremes
//   out_max_idx, out_min_idx : 0-based first position of each extreme
//   busy              : high in ACCUM or REPORT
module comp_minmax_tracker
    import comp_minmax_tracker_pkg::*;
#(
    parameter int WIN_LEN = DEFAULT_WIN_LEN,
    parameter int IDX_W   = DEFAULT_IDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [IDX_W-1:0]  out_max_idx,
    output logic [IDX_W-1:0]  out_min_idx,
    output logic              busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

    state_t            state_r;
    state_t            state_next_s;
    logic [IDX_W-1:0]  cnt_r;
    logic [DATA_W-1:0] max_r;
    logic [DATA_W-1:0] min_r;
    logic [IDX_W-1:0]  max_idx_r;
    logic [IDX_W-1:0]  min_idx_r;
    logic              in_ready_r;
    logic              out_valid_r;
    logic              busy_r;
    logic              in_ready_next_s;
    logic              out_valid_next_s;
    logic              busy_next_s;
    logic              accept_s;
    logic              first_s;
    logic              last_s;
    logic              start_take_s;
    logic              max_gt_s;
    logic              min_lt_s;
    logic              max_unused_lt_s;
    logic              min_unused_gt_s;

    // in_ready_r mirrors state ACCUM, so it doubles as the accept qualifier.
    assign accept_s     = in_valid & in_ready_r;
    assign first_s      = (cnt_r == {IDX_W{1'b0}});
    assign last_s       = accept_s & (cnt_r == LAST_IDX);
    assign start_take_s = (state_r == ST_IDLE) & start;

    comp_16 u_cmp_max (
        .a         (in_data),
        .b         (max_r),
        .in_A_G_B  (1'b0),
        .out_A_G_B (max_gt_s),
        .out_A_L_B (max_unused_lt_s)
    );

    comp_16 u_cmp_min (
        .a         (in_data),
        .b         (min_r),
        .in_A_G_B  (1'b0),
        .out_A_G_B (min_unused_gt_s),
        .out_A_L_B (min_lt_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; REPORT always exits to IDLE so a start seen in the
    // exit cycle is dropped.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (last_s) begin
                    state_next_s = ST_REPORT;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_REPORT: begin
                if (out_valid_r && out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_REPORT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the flags register alongside it.
    always_comb begin
        in_ready_next_s  = 1'b0;
        out_valid_next_s = 1'b0;
        busy_next_s      = 1'b0;
        case (state_next_s)
            ST_IDLE: begin
                busy_next_s = 1'b0;
            end
            ST_ACCUM: begin
                in_ready_next_s = 1'b1;
                busy_next_s     = 1'b1;
            end
            ST_REPORT: begin
                out_valid_next_s = 1'b1;
                busy_next_s      = 1'b1;
            end
            default: begin
                busy_next_s = 1'b0;
            end
        endcase
    end

    // Handshake/status flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= in_ready_next_s;
            out_valid_r <= out_valid_next_s;
            busy_r      <= busy_next_s;
        end
    end

    // Sample counter; holds at the last index so it never wraps in a window.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {IDX_W{1'b0}};
        end else if (start_take_s) begin
            cnt_r <= {IDX_W{1'b0}};
        end else if (accept_s && !last_s) begin
            cnt_r <= cnt_r + IDX_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Running maximum: sample 0 loads, later only a strictly larger sample
    // replaces it so ties keep the earlier index.
    always_ff @(posedge clk) begin
        if (rst) begin
            max_r     <= {DATA_W{1'b0}};
            max_idx_r <= {IDX_W{1'b0}};
        end else if (accept_s && (first_s || max_gt_s)) begin
            max_r     <= in_data;
            max_idx_r <= cnt_r;
        end else begin
            max_r     <= max_r;
            max_idx_r <= max_idx_r;
        end
    end

    // Running minimum: same policy as the maximum, strictly smaller only.
    always_ff @(posedge clk) begin
        if (rst) begin
            min_r     <= {DATA_W{1'b0}};
            min_idx_r <= {IDX_W{1'b0}};
        end else if (accept_s && (first_s || min_lt_s)) begin
            min_r     <= in_data;
            min_idx_r <= cnt_r;
        end else begin
            min_r     <= min_r;
            min_idx_r <= min_idx_r;
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign busy        = busy_r;
    assign out_max     = max_r;
    assign out_min     = min_r;
    assign out_max_idx = max_idx_r;
    assign out_min_idx = min_idx_r;

    // The opposite-direction comparator flags are not needed by this block.
    logic unused_cmp_s;
    assign unused_cmp_s = max_unused_lt_s ^ min_unused_gt_s;

endmodule : comp_minmax_tracker
